// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 16-bit asynchronous SRAM between the Mips
// instruction-fetch and data ports; each 32-bit word is two halfword accesses.
module ram_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP_LO = 3'd1,
    ACC_LO   = 3'd2,
    SETUP_HI = 3'd3,
    ACC_HI   = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic       PORT_I    = 1'b0;
  localparam logic       PORT_D    = 1'b1;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      next_state;
  logic        port;
  logic        we;
  logic [3:0]  be;
  logic [16:0] word;
  logic [31:0] wdata;
  logic        last_grant;
  logic [3:0]  cnt;
  logic [15:0] rd_lo;
  logic        data_oe;
  logic [15:0] data_out;

  logic        grant;
  logic        grant_port;
  logic        acc_last;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [16:0] sel_word;
  logic [31:0] sel_wdata;
  logic        hi_half;
  logic        active;
  logic        in_acc;
  logic [1:0]  half_be;
  logic        half_en;
  logic [17:0] n_addr;
  logic        n_wre;
  logic        n_oute;
  logic        n_hb;
  logic        n_lb;
  logic        n_ce;
  logic        n_oe;
  logic [15:0] n_dout;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:19], i_addr[1:0], d_addr[31:19], d_addr[1:0]};

  assign acc_last = (cnt == LAST_WAIT);
  assign data     = data_oe ? data_out : 16'hzzzz;

  // Next-state logic including round-robin arbitration in IDLE
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_port = PORT_I;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (last_grant == PORT_D))) begin
          grant      = 1'b1;
          grant_port = PORT_I;
          next_state = SETUP_LO;
        end else if (d_req) begin
          grant      = 1'b1;
          grant_port = PORT_D;
          next_state = SETUP_LO;
        end else begin
          next_state = IDLE;
        end
      end
      SETUP_LO: next_state = ACC_LO;
      ACC_LO:   next_state = acc_last ? SETUP_HI : ACC_LO;
      SETUP_HI: next_state = ACC_HI;
      ACC_HI:   next_state = acc_last ? DONE : ACC_HI;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Next SRAM pin values, derived from the state being entered so pins are registered
  always_comb begin
    if (grant) begin
      sel_we    = (grant_port == PORT_D) ? d_we : 1'b0;
      sel_be    = (grant_port == PORT_D) ? d_be : 4'b1111;
      sel_word  = (grant_port == PORT_D) ? d_addr[18:2] : i_addr[18:2];
      sel_wdata = (grant_port == PORT_D) ? d_wdata : 32'h0000_0000;
    end else begin
      sel_we    = we;
      sel_be    = be;
      sel_word  = word;
      sel_wdata = wdata;
    end
    hi_half = (next_state == SETUP_HI) || (next_state == ACC_HI);
    in_acc  = (next_state == ACC_LO) || (next_state == ACC_HI);
    active  = in_acc || (next_state == SETUP_LO) || (next_state == SETUP_HI);
    half_be = hi_half ? sel_be[3:2] : sel_be[1:0];
    // A write half with no byte enables leaves the SRAM completely untouched
    half_en = active && (!sel_we || (half_be != 2'b00));
    n_addr  = active ? {sel_word, hi_half} : addr;
    n_ce    = ~half_en;
    n_hb    = half_en ? (sel_we ? ~half_be[1] : 1'b0) : 1'b1;
    n_lb    = half_en ? (sel_we ? ~half_be[0] : 1'b0) : 1'b1;
    n_oute  = ~(in_acc && !sel_we);
    n_wre   = ~(in_acc && sel_we && half_en);
    n_oe    = active && sel_we;
    n_dout  = hi_half ? sel_wdata[31:16] : sel_wdata[15:0];
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Transaction latches, wait counter, read capture, acks and SRAM pin registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      port       <= PORT_I;
      we         <= 1'b0;
      be         <= 4'b0000;
      word       <= 17'd0;
      wdata      <= 32'h0000_0000;
      last_grant <= PORT_D;
      cnt        <= 4'd0;
      rd_lo      <= 16'h0000;
      i_rdata    <= 32'h0000_0000;
      d_rdata    <= 32'h0000_0000;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      addr       <= 18'd0;
      wre        <= 1'b1;
      oute       <= 1'b1;
      hb_mask    <= 1'b1;
      lb_mask    <= 1'b1;
      chip_en    <= 1'b1;
      data_oe    <= 1'b0;
      data_out   <= 16'h0000;
    end else begin
      if (grant) begin
        port  <= grant_port;
        we    <= sel_we;
        be    <= sel_be;
        word  <= sel_word;
        wdata <= sel_wdata;
      end
      if ((state == ACC_LO) || (state == ACC_HI)) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
      if ((state == ACC_LO) && acc_last && !we) begin
        rd_lo <= data;
      end
      if ((state == ACC_HI) && acc_last) begin
        last_grant <= port;
        if (!we && (port == PORT_I)) begin
          i_rdata <= {data, rd_lo};
        end
        if (!we && (port == PORT_D)) begin
          d_rdata <= {data, rd_lo};
        end
      end
      i_ack    <= (next_state == DONE) && (port == PORT_I);
      d_ack    <= (next_state == DONE) && (port == PORT_D);
      addr     <= n_addr;
      wre      <= n_wre;
      oute     <= n_oute;
      hb_mask  <= n_hb;
      lb_mask  <= n_lb;
      chip_en  <= n_ce;
      data_oe  <= n_oe;
      data_out <= n_dout;
    end
  end

endmodule
